iter_div_unit: RTL
==================

Name: iter_div_unit

Overview:
Multi-cycle radix-2 restoring integer divider. It replaces the single-cycle combinational divide path in the execute functional units. It supports signed and unsigned operands, returns the quotient or the remainder, and uses a valid/ready handshake on both sides. A flush input cancels an in-flight operation on a pipeline redirect. The datapath width is parametrised so the same block serves the 32-bit core and narrower test builds.

Parameters:
WIDTH, 32, operand and result width in bits (WIDTH >= 4).
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
clk  in  1  clock, all state updates on the rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous cancel of any operation in progress
in_valid  in  1  request valid
in_ready  out  1  block can accept a request this cycle
is_unsigned  in  1  1 = unsigned divide, 0 = signed (two's complement)
use_mod  in  1  1 = return remainder, 0 = return quotient
src1  in  WIDTH  dividend
src2  in  WIDTH  divisor
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
result  out  WIDTH  quotient or remainder, held stable while out_valid=1 and out_ready=0
busy  out  1  state != IDLE

Behaviour:
- Reset: the already-decided rule is one clock `clk`, with a synchronous, active-high `reset`. On reset: state=IDLE, out_valid=0, result=0, busy=0, in_ready=1, counter=0, all datapath registers 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&in_ready at a clock edge. Latch is_unsigned, use_mod, the operand signs, and |src1| and |src2| (plain values when unsigned).
  - Special-case check at accept:
    - src2==0: go to DONE. Quotient = all ones, remainder = src1 (the original, unmodified value).
    - Signed, src1 = 1 followed by zeros (most negative value), src2 = all ones (-1): go to DONE. Quotient = src1, remainder = 0.
    - Otherwise: go to CALC, counter=WIDTH, partial remainder=0.
- CALC:
  - One quotient bit per cycle.
  - Shift {rem, dividend} left by 1. If shifted rem >= divisor magnitude, subtract the divisor and set the quotient bit to 1; else set it to 0.
  - Counter decrements each cycle. When counter==1 the last iteration latches and state goes to DONE.
- DONE:
  - out_valid=1.
  - Signed fixup is applied before the result register loads:
    - Quotient is negated if sign1^sign2.
    - Remainder is negated if sign1 (truncating division; the remainder takes the dividend's sign).
  - result = remainder if use_mod, else quotient.
  - On out_valid&out_ready: go to IDLE. out_valid drops next cycle. A new request is accepted no earlier than the cycle after.
- Latency, from accept edge to the first cycle out_valid=1:
  - WIDTH cycles for the normal path.
  - 1 cycle for the divide-by-zero and overflow cases.
- in_ready=0 in CALC and DONE. There is no request queueing.
- flush:
  - From any state, the next state is IDLE and out_valid goes to 0 on the next edge.
  - flush has priority over in_valid in the same cycle: nothing is accepted.
  - flush has priority over out_ready: the result is discarded.
- Reset has priority over flush. Reset mid-CALC or mid-DONE aborts with no output.
- Inputs are sampled only at the accept edge. Changes to src1, src2 or the mode bits afterwards do not affect the result.
- Arithmetic:
  - Magnitudes are WIDTH bits. The most negative value's magnitude, 1 followed by zeros, is treated as unsigned.
  - The partial-remainder subtractor is WIDTH+1 bits so the comparison never overflows.

Test Plan:
- Unsigned 100/7, use_mod=0, then use_mod=1 -> result 14 then 2. out_valid exactly WIDTH=32 cycles after each accept edge.
- Signed -7/2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Signed 7/-2 -> quotient -3, remainder 1.
- src2=0, src1=0x12345678 -> quotient 0xFFFFFFFF, remainder 0x12345678. Both out_valid 1 cycle after accept.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, latency 1. The same operands unsigned -> quotient 0, remainder 0x80000000 after 32 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0. Raise out_ready -> IDLE next cycle, in_ready=1.
- Assert flush at CALC cycle 10 (and, separately, together with in_valid in IDLE) -> IDLE next cycle, out_valid never rises. The next request 0xFFFFFFFF/0x10 (unsigned) -> 0x0FFFFFFF. Reset asserted mid-CALC gives the same abort.

Source files
------------

// File: rtl/iter_div_unit.sv
// Radix-2 restoring divider, signed/unsigned, quotient or remainder; WIDTH cycles accept-to-valid (1 for divide-by-zero/overflow).
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready; flush discards any operation in progress.
module iter_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_unsigned,
  input  logic             use_mod,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d, result_q, result_d;
  logic             sign1_q, sign1_d, sign2_q, sign2_d, use_mod_q, use_mod_d;
  logic             special_q, special_d;
  logic             out_valid_q, out_valid_d, in_ready_q, in_ready_d, busy_q, busy_d;

  logic             neg1, neg2, ge;
  logic [WIDTH-1:0] mag1, mag2, rem_nxt, quo_nxt, rem_fix, quo_fix;
  logic [WIDTH:0]   shifted, diff;

  always_comb begin
    neg1    = !is_unsigned && src1[WIDTH-1];
    neg2    = !is_unsigned && src2[WIDTH-1];
    mag1    = neg1 ? -src1 : src1;
    mag2    = neg2 ? -src2 : src2;
    // rem < divisor, so the WIDTH+1-bit difference always has a valid sign bit
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, div_q};
    ge      = !diff[WIDTH];
    rem_nxt = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], ge};
    quo_fix = (sign1_q ^ sign2_q) ? -quo_nxt : quo_nxt;
    rem_fix = sign1_q ? -rem_nxt : rem_nxt;

    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    result_d    = result_q;
    sign1_d     = sign1_q;
    sign2_d     = sign2_q;
    use_mod_d   = use_mod_q;
    special_d   = special_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q && !flush) begin
          sign1_d   = neg1;
          sign2_d   = neg2;
          use_mod_d = use_mod;
          quo_d     = mag1;
          div_d     = mag2;
          rem_d     = '0;
          state_d   = CALC;
          // Special cases preload the result and spend one CALC cycle so out_valid rises one edge after accept
          if (src2 == '0) begin
            special_d = 1'b1;
            cnt_d     = CNT_ONE;
            result_d  = use_mod ? src1 : '1;
          end else if (!is_unsigned && src1 == MIN_NEG && src2 == '1) begin
            special_d = 1'b1;
            cnt_d     = CNT_ONE;
            result_d  = use_mod ? '0 : src1;
          end else begin
            special_d = 1'b0;
            cnt_d     = CNT_INIT;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q - CNT_ONE;
        if (!special_q) begin
          rem_d = rem_nxt;
          quo_d = quo_nxt;
        end
        if (cnt_q == CNT_ONE) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          if (!special_q) result_d = use_mod_q ? rem_fix : quo_fix;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      result_q    <= '0;
      sign1_q     <= 1'b0;
      sign2_q     <= 1'b0;
      use_mod_q   <= 1'b0;
      special_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      result_q    <= result_d;
      sign1_q     <= sign1_d;
      sign2_q     <= sign2_d;
      use_mod_q   <= use_mod_d;
      special_q   <= special_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule
